// File: rtl/condicionador_botoes_pkg.sv
// Shared definitions for the button conditioner: press FSM states, button count
// and the small vector helpers used by the press FSM.
package condicionador_botoes_pkg;

    localparam int N_BOTOES = 7;

    typedef enum logic [1:0] {
        OCIOSO      = 2'd0,
        PRESSIONADO = 2'd1,
        BLOQUEADO   = 2'd2
    } estado_t;

    function automatic logic [2:0] contar_uns(input logic [N_BOTOES-1:0] v);
        logic [2:0] total;
        total = '0;
        for (int i = 0; i < N_BOTOES; i++) begin
            total = total + {2'b00, v[i]};
        end
        return total;
    endfunction

    // Note code is the button index plus one, so that zero can mean "no button".
    function automatic logic [2:0] codigo_de(input logic [N_BOTOES-1:0] v);
        logic [2:0] cod;
        cod = '0;
        for (int i = 0; i < N_BOTOES; i++) begin
            if (v[i]) begin
                cod = 3'(i + 1);
            end
        end
        return cod;
    endfunction

endpackage

// File: rtl/condicionador_botoes_if.sv
// Raw button/key pins in, conditioned button levels, pulse and note code out.
interface condicionador_botoes_if;
    import condicionador_botoes_pkg::*;

    logic [N_BOTOES-1:0] botoes_brutos;
    logic                jogar_bruto;
    logic [N_BOTOES-1:0] botoes;
    logic                jogar;
    logic                pulso_botao;
    logic [2:0]          codigo_botao;
    logic                multiplos;

    modport master (
        output botoes_brutos, jogar_bruto,
        input  botoes, jogar, pulso_botao, codigo_botao, multiplos
    );

    modport slave (
        input  botoes_brutos, jogar_bruto,
        output botoes, jogar, pulso_botao, codigo_botao, multiplos
    );

endinterface

// File: rtl/condicionador_botoes_debouncer_sinal.sv
// Two-flop synchronizer followed by a stability counter for one raw input bit.
module debouncer_sinal #(
    parameter int DEBOUNCE_CICLOS = 50000
) (
    input  logic clock,
    input  logic reset,
    input  logic bruto,
    output logic estavel
);

    localparam int CW = (DEBOUNCE_CICLOS > 1) ? $clog2(DEBOUNCE_CICLOS) : 1;
    localparam logic [CW-1:0] LIMITE = CW'(DEBOUNCE_CICLOS - 1);

    logic          sinc_a;
    logic          sinc_b;
    logic [CW-1:0] contador;

    // The level only flips after DEBOUNCE_CICLOS consecutive differing samples.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sinc_a   <= 1'b0;
            sinc_b   <= 1'b0;
            estavel  <= 1'b0;
            contador <= '0;
        end else begin
            sinc_a <= bruto;
            sinc_b <= sinc_a;
            if (sinc_b == estavel) begin
                contador <= '0;
            end else if (contador == LIMITE) begin
                estavel  <= ~estavel;
                contador <= '0;
            end else begin
                contador <= contador + CW'(1);
            end
        end
    end

endmodule

// File: rtl/condicionador_botoes.sv
// Conditions the note buttons and start key: synchronize, debounce, then accept
// exactly one button at a time with a one-cycle press pulse and a note code.
module condicionador_botoes
    import condicionador_botoes_pkg::*;
#(
    parameter int DEBOUNCE_CICLOS = 50000
) (
    input  logic                 clock,
    input  logic                 reset,
    condicionador_botoes_if.slave sinais
);

    logic [N_BOTOES:0]   brutos;
    logic [N_BOTOES:0]   estaveis;
    logic [N_BOTOES-1:0] d;
    logic [2:0]          quantidade;

    estado_t             estado;
    logic [N_BOTOES-1:0] botoes_r;
    logic [2:0]          codigo_r;
    logic                pulso_r;
    logic                multiplos_r;

    // The start key rides along as the top bit so all eight inputs share one debouncer array.
    assign brutos = {sinais.jogar_bruto, sinais.botoes_brutos};

    generate
        for (genvar i = 0; i <= N_BOTOES; i++) begin : g_debounce
            debouncer_sinal #(
                .DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)
            ) u_debouncer (
                .clock  (clock),
                .reset  (reset),
                .bruto  (brutos[i]),
                .estavel(estaveis[i])
            );
        end
    endgenerate

    assign d          = estaveis[N_BOTOES-1:0];
    assign quantidade = contar_uns(d);

    // Any change away from the latched one-hot ends the press; a new button can only
    // be accepted after every button has been released.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado      <= OCIOSO;
            botoes_r    <= '0;
            codigo_r    <= '0;
            pulso_r     <= 1'b0;
            multiplos_r <= 1'b0;
        end else begin
            pulso_r <= 1'b0;
            case (estado)
                OCIOSO: begin
                    if (quantidade == 3'd1) begin
                        estado   <= PRESSIONADO;
                        botoes_r <= d;
                        codigo_r <= codigo_de(d);
                        pulso_r  <= 1'b1;
                    end else if (quantidade >= 3'd2) begin
                        estado      <= BLOQUEADO;
                        multiplos_r <= 1'b1;
                    end
                end
                PRESSIONADO: begin
                    if (d != botoes_r) begin
                        botoes_r <= '0;
                        codigo_r <= '0;
                        if (d == '0) begin
                            estado <= OCIOSO;
                        end else begin
                            estado      <= BLOQUEADO;
                            multiplos_r <= 1'b1;
                        end
                    end
                end
                BLOQUEADO: begin
                    if (d == '0) begin
                        estado      <= OCIOSO;
                        multiplos_r <= 1'b0;
                    end
                end
                default: begin
                    estado      <= OCIOSO;
                    botoes_r    <= '0;
                    codigo_r    <= '0;
                    multiplos_r <= 1'b0;
                end
            endcase
        end
    end

    assign sinais.botoes       = botoes_r;
    assign sinais.codigo_botao = codigo_r;
    assign sinais.pulso_botao  = pulso_r;
    assign sinais.multiplos    = multiplos_r;
    assign sinais.jogar        = estaveis[N_BOTOES];

endmodule

// File: tb/tb_condicionador_botoes.sv
// Scoreboard bench for condicionador_botoes: a stability-window reference model
// predicts every output cycle, and a monitor compares at each falling edge.
module tb_condicionador_botoes;

    localparam int D = 4;

    typedef struct packed {
        logic [6:0] botoes;
        logic [2:0] codigo;
        logic       pulso;
        logic       multiplos;
        logic       jogar;
    } saida_t;

    typedef enum {M_LIVRE, M_TRAVADO, M_CONFLITO} modo_t;

    logic clock;
    logic reset;

    condicionador_botoes_if intf ();

    condicionador_botoes #(
        .DEBOUNCE_CICLOS(D)
    ) dut (
        .clock (clock),
        .reset (reset),
        .sinais(intf)
    );

    int checks;
    int failures;
    int pulsos_vistos;
    int pulsos_esperados;

    saida_t     exp_q[$];
    logic [2:0] pulso_q[$];

    logic [7:0] hist[$];
    logic [7:0] m_s;
    modo_t      m_modo;
    logic [6:0] m_lat;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic verificar(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        checks++;
        if (atual !== esperado) begin
            failures++;
            $display("[TB] FAIL %s: atual=%0h esperado=%0h (t=%0t)", nome, atual, esperado, $time);
        end
    endtask

    function automatic saida_t ler_dut();
        saida_t s;
        s.botoes    = intf.botoes;
        s.codigo    = intf.codigo_botao;
        s.pulso     = intf.pulso_botao;
        s.multiplos = intf.multiplos;
        s.jogar     = intf.jogar;
        return s;
    endfunction

    function automatic logic [2:0] nota(input logic [6:0] v);
        for (int i = 0; i < 7; i++) begin
            if (v[i]) return 3'(i + 1);
        end
        return 3'd0;
    endfunction

    // Reference: a debounced level flips once the last D synchronized samples all disagree with it;
    // the press logic reacts to the level held before this edge.
    task automatic modelo_passo();
        logic [6:0] dv;
        logic       pulso;
        logic       mudou;
        int         n;
        saida_t     e;
        pulso = 1'b0;
        if (reset) begin
            hist.delete();
            for (int i = 0; i < D + 2; i++) hist.push_back(8'h00);
            m_s    = 8'h00;
            m_modo = M_LIVRE;
            m_lat  = 7'h00;
        end else begin
            dv = m_s[6:0];
            n  = $countones(dv);
            case (m_modo)
                M_LIVRE: begin
                    if (n == 1) begin
                        m_modo = M_TRAVADO;
                        m_lat  = dv;
                        pulso  = 1'b1;
                    end else if (n >= 2) begin
                        m_modo = M_CONFLITO;
                    end
                end
                M_TRAVADO: begin
                    if (dv != m_lat) m_modo = (n == 0) ? M_LIVRE : M_CONFLITO;
                end
                default: begin
                    if (n == 0) m_modo = M_LIVRE;
                end
            endcase
            hist.push_back({intf.jogar_bruto, intf.botoes_brutos});
            if (hist.size() > D + 2) void'(hist.pop_front());
            for (int b = 0; b < 8; b++) begin
                mudou = 1'b1;
                for (int j = 0; j < D; j++) begin
                    if (hist[hist.size() - 3 - j][b] == m_s[b]) mudou = 1'b0;
                end
                if (mudou) m_s[b] = ~m_s[b];
            end
        end
        e.botoes    = (m_modo == M_TRAVADO) ? m_lat : 7'h00;
        e.codigo    = (m_modo == M_TRAVADO) ? nota(m_lat) : 3'd0;
        e.pulso     = pulso;
        e.multiplos = (m_modo == M_CONFLITO);
        e.jogar     = m_s[7];
        exp_q.push_back(e);
        if (pulso) begin
            pulso_q.push_back(e.codigo);
            pulsos_esperados++;
        end
    endtask

    initial begin
        for (int i = 0; i < D + 2; i++) hist.push_back(8'h00);
        m_s    = 8'h00;
        m_modo = M_LIVRE;
        m_lat  = 7'h00;
        forever begin
            @(posedge clock);
            modelo_passo();
        end
    end

    // Monitor: pops one expected output per cycle, and one expected note code per observed pulse.
    initial begin
        saida_t e;
        saida_t a;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = ler_dut();
                verificar("saidas", 32'(a), 32'(e));
                if (a.pulso) begin
                    pulsos_vistos++;
                    if (pulso_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("[TB] FAIL pulso_inesperado: atual=1 esperado=0 codigo=%0d (t=%0t)", a.codigo, $time);
                    end else begin
                        verificar("codigo_pulso", 32'(a.codigo), 32'(pulso_q.pop_front()));
                    end
                end
            end
        end
    end

    task automatic applyStimulus(input logic [6:0] b, input int n);
        @(negedge clock);
        intf.botoes_brutos = b;
        repeat (n - 1) @(negedge clock);
    endtask

    task automatic aplicar_reset(input logic [6:0] b);
        @(negedge clock);
        intf.botoes_brutos = b;
        #2 reset = 1'b1;
        #1 verificar("reset_imediato", 32'(ler_dut()), 32'd0);
        repeat (2) @(negedge clock);
        #2 reset = 1'b0;
    endtask

    task automatic checkOutput(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        verificar(nome, atual, esperado);
    endtask

    int   marca;
    int   pulso_em;
    int   solto_em;
    int   subidas;
    int   subiu_em;
    logic jogar_ant;

    task automatic amostrar_jogar(input int i);
        @(posedge clock);
        #1;
        if (intf.jogar && !jogar_ant) begin
            subidas++;
            if (subiu_em == 0) subiu_em = i;
        end
        jogar_ant = intf.jogar;
    endtask

    initial begin
        logic [6:0] padrao;
        checks = 0; failures = 0; pulsos_vistos = 0; pulsos_esperados = 0;
        reset = 1'b1;
        intf.botoes_brutos = 7'h00;
        intf.jogar_bruto   = 1'b0;
        repeat (3) @(negedge clock);
        #2 reset = 1'b0;
        applyStimulus(7'h00, 10);
        checkOutput("ocioso_apos_reset", 32'(ler_dut()), 32'd0);

        $display("[TB] clean single press");
        @(negedge clock);
        intf.botoes_brutos = 7'b0000100;
        pulso_em = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clock);
            #1;
            if (intf.pulso_botao && pulso_em == 0) pulso_em = i;
            if (i == 10) begin
                checkOutput("botoes_segurado", 32'(intf.botoes), 32'h04);
                checkOutput("codigo_segurado", 32'(intf.codigo_botao), 32'd3);
            end
        end
        checkOutput("latencia_pulso", pulso_em, 7);
        @(negedge clock);
        intf.botoes_brutos = 7'h00;
        solto_em = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clock);
            #1;
            if (intf.botoes == 7'h00 && solto_em == 0) solto_em = i;
        end
        checkOutput("latencia_soltura", solto_em, 7);

        $display("[TB] glitch rejection");
        marca = pulsos_vistos;
        @(negedge clock);
        intf.botoes_brutos = 7'b0000001;
        repeat (3) @(negedge clock);
        intf.botoes_brutos = 7'h00;
        repeat (12) @(negedge clock);
        checkOutput("glitch_sem_pulso", pulsos_vistos, marca);

        $display("[TB] second button while holding");
        applyStimulus(7'b0000010, 12);
        applyStimulus(7'b0100010, 12);
        checkOutput("segundo_botoes", 32'(intf.botoes), 32'h00);
        checkOutput("segundo_multiplos", 32'(intf.multiplos), 32'd1);
        marca = pulsos_vistos;
        applyStimulus(7'b0000010, 12);
        checkOutput("solta_extra_bloqueado", 32'(intf.multiplos), 32'd1);
        applyStimulus(7'h00, 12);
        checkOutput("solta_tudo_ocioso", 32'(intf.multiplos), 32'd0);
        checkOutput("bloqueado_sem_pulso", pulsos_vistos, marca);
        applyStimulus(7'b0100000, 10);
        checkOutput("codigo_bit5", 32'(intf.codigo_botao), 32'd6);
        applyStimulus(7'h00, 12);

        $display("[TB] simultaneous press");
        marca = pulsos_vistos;
        applyStimulus(7'b0001100, 15);
        checkOutput("simultaneo_multiplos", 32'(intf.multiplos), 32'd1);
        checkOutput("simultaneo_sem_pulso", pulsos_vistos, marca);
        applyStimulus(7'h00, 12);
        checkOutput("simultaneo_liberado", 32'(intf.multiplos), 32'd0);

        $display("[TB] jogar path with a button held");
        applyStimulus(7'b0001000, 12);
        jogar_ant = intf.jogar;
        subidas = 0;
        subiu_em = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            intf.jogar_bruto = (k % 2 == 0);
            amostrar_jogar(-1);
        end
        @(negedge clock);
        intf.jogar_bruto = 1'b1;
        for (int i = 1; i <= 15; i++) amostrar_jogar(i);
        checkOutput("jogar_latencia", subiu_em, 6);
        checkOutput("jogar_uma_subida", subidas, 1);
        checkOutput("jogar_botao_intacto", 32'(intf.codigo_botao), 32'd4);
        @(negedge clock);
        intf.jogar_bruto = 1'b0;
        applyStimulus(7'h00, 12);

        $display("[TB] reset mid-press with all buttons held");
        applyStimulus(7'b0000001, 10);
        aplicar_reset(7'h7F);
        marca = pulsos_vistos;
        repeat (10) @(negedge clock);
        checkOutput("reset_7f_multiplos", 32'(intf.multiplos), 32'd1);
        checkOutput("reset_7f_sem_pulso", pulsos_vistos, marca);
        applyStimulus(7'h00, 12);

        $display("[TB] randomized phase");
        for (int it = 0; it < 250; it++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: padrao = 7'(1 << $urandom_range(0, 6));
                5, 6:          padrao = 7'h00;
                default:       padrao = 7'($urandom_range(0, 127));
            endcase
            if ($urandom_range(0, 3) == 0) intf.jogar_bruto = ~intf.jogar_bruto;
            if ($urandom_range(0, 29) == 0) aplicar_reset(padrao);
            applyStimulus(padrao, $urandom_range(1, 10));
        end

        intf.jogar_bruto = 1'b0;
        applyStimulus(7'h00, 30);
        checkOutput("pulsos_pendentes", pulso_q.size(), 0);
        checkOutput("total_pulsos", pulsos_vistos, pulsos_esperados);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/condicionador_botoes.md
Name: condicionador_botoes

Overview:
Input conditioner that sits directly upstream of the game top level. It feeds the top level's botoes[6:0] and jogar inputs.
- Synchronizes the 7 raw note buttons and the raw jogar key to clock, then debounces each one.
- Runs a press FSM that accepts exactly one button at a time and emits a clean one-hot level, a 1-cycle press pulse and a 3-bit note code.
- Simultaneous presses are rejected, so the datapath comparison against memory only ever sees a single button.

Parameters:
N_BOTOES, 7, number of note buttons (one-hot width).
DEBOUNCE_CICLOS, 50000, consecutive stable synchronized cycles required to accept a level change (1 ms at 50 MHz).
CW, $clog2(DEBOUNCE_CICLOS), debounce counter width (derived, not overridden).

Ports:
clock  in  1  system clock, all state on rising edge.
reset  in  1  asynchronous, active-high; clears all state.
botoes_brutos  in  N_BOTOES  raw active-high button pins, asynchronous to clock.
jogar_bruto  in  1  raw active-high start key.
botoes  out  N_BOTOES  one-hot accepted button, held while pressed; 0 otherwise.
jogar  out  1  debounced level of jogar_bruto (the top level edge-detects it).
pulso_botao  out  1  single-cycle pulse when a button is accepted.
codigo_botao  out  3  index+1 of accepted button (1..7); 0 when none.
multiplos  out  1  high while in state BLOQUEADO (debug).

Behaviour:
- Reset (async): sync flops, debounced levels and counters go to 0; FSM goes to OCIOSO. All outputs are 0 while reset is high and in the first cycle after it is released.
- Synchronizer: 2-flop chain per input (8 chains), reset to 0.
- Debounce, per input:
  - Keeps a stable level s and a counter c.
  - If sync output equals s, c clears to 0.
  - Otherwise c increments. When c == DEBOUNCE_CICLOS-1 and the input still differs, s toggles on that edge and c clears.
  - A glitch shorter than DEBOUNCE_CICLOS cycles never changes s. Release is debounced identically.
- Latency: a raw change held steady reaches s after exactly DEBOUNCE_CICLOS+2 clock edges. The FSM reacts on the next edge, so raw→pulso_botao is DEBOUNCE_CICLOS+3 edges.
- FSM (registered outputs, d = debounced button vector):
  - OCIOSO: botoes=0, codigo=0. If popcount(d)==1 → PRESSIONADO, latching the index. If popcount(d)>=2 → BLOQUEADO. Otherwise stay.
  - PRESSIONADO:
    - botoes = one-hot of latched index; codigo = index+1.
    - pulso_botao = 1 only in the first cycle of this state.
    - Latched bit cleared with d==0 → OCIOSO.
    - Any other bit set (additional press) → BLOQUEADO, and botoes drops to 0 immediately.
    - Latched bit cleared while another bit is set → BLOQUEADO (no re-accept without a full release).
  - BLOQUEADO: botoes=0, codigo=0, multiplos=1. Stay until d==0, then → OCIOSO. No pulse is ever emitted from or into this state.
- Only one pulso_botao per press; holding a button never repeats the pulse.
- jogar path is independent of the FSM: jogar = debounced level, no pulse generation here.
- Reset mid-press: state returns to OCIOSO. A button still physically held after reset must be debounced again (s starts at 0) and then produces a fresh pulse.
- codigo_botao encoding: bit0→1 … bit6→7. Values 0 and 1..7 only. This 3-bit code matches the note code width of arduino_out.

Decomposition:
- Shared package: FSM state encoding (OCIOSO=2'd0, PRESSIONADO=2'd1, BLOQUEADO=2'd2) and constant N_BOTOES=7.
- One sub-module, debouncer_sinal: 2-flop sync plus counter for one bit, parameter DEBOUNCE_CICLOS. Instantiated 8 times via generate.
- FSM, popcount and one-hot-to-index encoding live in the top of this block.

Test Plan (DEBOUNCE_CICLOS=4):
- Reset: assert reset mid-cycle with botoes_brutos=7'h7F → all outputs 0 immediately; after release, DEBOUNCE_CICLOS+3 edges later pulso_botao=1 is not expected (multiple buttons) and multiplos=1.
- Clean single press: botoes_brutos=7'b0000100 held 20 cycles → pulso_botao=1 for exactly 1 cycle at edge 7 after the change; botoes=7'b0000100 and codigo_botao=3 until 7 edges after release, then 0.
- Glitch rejection: bit0 high for 3 cycles then low → no pulse, botoes stays 0, codigo 0 throughout.
- Second button while holding: hold bit1, after pulse add bit5 → botoes drops to 0 and multiplos=1 once bit5 debounces. Release bit5 only → stays BLOQUEADO, no pulse. Release bit1 → OCIOSO. Then press bit5 alone → one pulse, codigo=6.
- Simultaneous press: bits 2 and 3 rise in the same cycle → never pulses, multiplos=1 until both released.
- jogar path: jogar_bruto bouncing 1-0-1-0 at 1-cycle spacing then steady 1 → jogar rises once, exactly 6 edges after the final steady edge, independent of button FSM state.
